// File: rtl/spart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single SPART Avalon-MM slave port.
// One transaction in flight; unanswered commands time out with DECODEERROR, bursts get SLVERR.
module spart_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    input  logic [4:0]  m0_burstcount,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    output logic        m0_writeresponsevalid,
    output logic [1:0]  m0_response,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    input  logic [4:0]  m1_burstcount,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        m1_writeresponsevalid,
    output logic [1:0]  m1_response,
    output logic [29:0] bus_address,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    output logic [4:0]  bus_burstcount,
    output logic        bus_read,
    output logic        bus_write,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    input  logic        s_readdatavalid,
    input  logic        s_writeresponsevalid,
    input  logic [1:0]  s_response
);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, ERR_RESP} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             is_read, is_read_nxt;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        req0, req1, grant, grant_wait;
    logic        sel_read, sel_write;
    logic [4:0]  sel_burstcount;
    logic        rsp_fire, rsp_is_read;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_code;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        req0           = m0_read | m0_write;
        req1           = m1_read | m1_write;
        grant          = (req0 && req1) ? ~last_grant : req1;
        sel_read       = grant ? m1_read       : m0_read;
        sel_write      = grant ? m1_write      : m0_write;
        sel_burstcount = grant ? m1_burstcount : m0_burstcount;
        bus_address    = grant ? m1_address    : m0_address;
        bus_writedata  = grant ? m1_writedata  : m0_writedata;
        bus_byteenable = grant ? m1_byteenable : m0_byteenable;
        bus_burstcount = 5'd1;
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        is_read_nxt    = is_read;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        grant_wait     = 1'b1;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        rsp_fire       = 1'b0;
        rsp_is_read    = 1'b0;
        rsp_data       = 32'h0;
        rsp_code       = 2'b00;

        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (sel_burstcount == 5'd1) begin
                            bus_read   = sel_read;
                            bus_write  = sel_write;
                            grant_wait = s_waitrequest;
                            if (!s_waitrequest) begin
                                owner_nxt      = grant;
                                is_read_nxt    = sel_read;
                                last_grant_nxt = grant;
                                cnt_nxt        = '0;
                                state_nxt      = WAIT_RESP;
                            end
                        end else begin
                            // Bursts are never forwarded; the master gets SLVERR next cycle.
                            grant_wait     = 1'b0;
                            owner_nxt      = grant;
                            is_read_nxt    = sel_read;
                            last_grant_nxt = grant;
                            state_nxt      = ERR_RESP;
                        end
                        if (grant) m1_waitrequest = grant_wait;
                        else       m0_waitrequest = grant_wait;
                    end
                end
                WAIT_RESP: begin
                    if (s_readdatavalid || s_writeresponsevalid) begin
                        rsp_fire    = 1'b1;
                        rsp_is_read = s_readdatavalid;
                        rsp_data    = s_readdata;
                        rsp_code    = s_response;
                        state_nxt   = IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_fire    = 1'b1;
                        rsp_is_read = is_read;
                        rsp_code    = 2'b11;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ERR_RESP: begin
                    rsp_fire    = 1'b1;
                    rsp_is_read = is_read;
                    rsp_code    = 2'b10;
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Only the owner ever sees a response; the other master stays quiet.
    always_comb begin
        m0_readdata           = 32'h0;
        m0_response           = 2'b00;
        m0_readdatavalid      = 1'b0;
        m0_writeresponsevalid = 1'b0;
        m1_readdata           = 32'h0;
        m1_response           = 2'b00;
        m1_readdatavalid      = 1'b0;
        m1_writeresponsevalid = 1'b0;
        if (rsp_fire) begin
            if (owner) begin
                m1_readdata           = rsp_data;
                m1_response           = rsp_code;
                m1_readdatavalid      = rsp_is_read;
                m1_writeresponsevalid = ~rsp_is_read;
            end else begin
                m0_readdata           = rsp_data;
                m0_response           = rsp_code;
                m0_readdatavalid      = rsp_is_read;
                m0_writeresponsevalid = ~rsp_is_read;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            is_read    <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            is_read    <= is_read_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: the bench plays the SPART slave cycle by cycle.
module tb_spart_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] m0_address, m1_address;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [4:0]  m0_burstcount, m1_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_writeresponsevalid, m1_writeresponsevalid;
    logic [1:0]  m0_response, m1_response;
    logic [29:0] bus_address;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic [4:0]  bus_burstcount;
    logic        bus_read, bus_write;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid, s_writeresponsevalid;
    logic [1:0]  s_response;

    int tests_run = 0;
    int tests_failed = 0;
    int w0, w1;

    spart_bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_writeresponsevalid(m0_writeresponsevalid),
        .m0_response(m0_response),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_burstcount(m1_burstcount), .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_writeresponsevalid(m1_writeresponsevalid),
        .m1_response(m1_response),
        .bus_address(bus_address), .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
        .bus_burstcount(bus_burstcount), .bus_read(bus_read), .bus_write(bus_write),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input int m, input logic rd, input logic wr, input logic [29:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] burst);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = wdata;
            m0_byteenable = 4'hf; m0_burstcount = burst;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = wdata;
            m1_byteenable = 4'hf; m1_burstcount = burst;
        end
    endtask

    task automatic slaveDrive(input logic rv, input logic wv, input logic [31:0] data, input logic [1:0] resp);
        s_readdatavalid = rv; s_writeresponsevalid = wv; s_readdata = data; s_response = resp;
    endtask

    task automatic idleAll();
        applyStimulus(0, 1'b0, 1'b0, 30'h0, 32'h0, 5'd1);
        applyStimulus(1, 1'b0, 1'b0, 30'h0, 32'h0, 5'd1);
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);
        s_waitrequest = 1'b0;
    endtask

    task automatic doReset();
        idleAll();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idleAll();
        tick();
        settle();
        checkOutput("rst_m0_wait", m0_waitrequest, 1);
        checkOutput("rst_m1_wait", m1_waitrequest, 1);
        checkOutput("rst_bus_rw", {bus_read, bus_write}, 0);
        checkOutput("rst_strobes", {m0_readdatavalid, m0_writeresponsevalid, m1_readdatavalid, m1_writeresponsevalid}, 0);
        checkOutput("rst_rdata", m0_readdata | m1_readdata, 0);
        checkOutput("rst_resp", {m0_response, m1_response}, 0);
        tick();
        rst_n = 1'b1;

        // Plain read of the RX register by m0
        applyStimulus(0, 1'b1, 1'b0, 30'h3e0011, 32'h0, 5'd1);
        settle();
        checkOutput("t1_bus_read", bus_read, 1);
        checkOutput("t1_bus_addr", bus_address, 30'h3e0011);
        checkOutput("t1_burst", bus_burstcount, 1);
        checkOutput("t1_m0_wait", m0_waitrequest, 0);
        checkOutput("t1_m1_wait", m1_waitrequest, 1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 30'h0, 32'h0, 5'd1);
        slaveDrive(1'b1, 1'b0, 32'h41000000, 2'b00);
        settle();
        checkOutput("t1_bus_read_off", bus_read, 0);
        checkOutput("t1_m0_rvalid", m0_readdatavalid, 1);
        checkOutput("t1_m0_rdata", m0_readdata, 32'h41000000);
        checkOutput("t1_m0_resp", m0_response, 0);
        checkOutput("t1_m1_strobes", {m1_readdatavalid, m1_writeresponsevalid}, 0);
        tick();
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);

        // Simultaneous reads after reset, twice
        doReset();
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(0, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
            applyStimulus(1, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
            settle();
            checkOutput("t2_m0_first", m0_waitrequest, 0);
            checkOutput("t2_m1_held", m1_waitrequest, 1);
            tick();
            m0_read = 1'b0;
            slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
            settle();
            checkOutput("t2_m0_rvalid", m0_readdatavalid, 1);
            checkOutput("t2_m1_quiet", m1_readdatavalid, 0);
            checkOutput("t2_m1_wait_busy", m1_waitrequest, 1);
            tick();
            slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);
            settle();
            checkOutput("t2_m1_granted", m1_waitrequest, 0);
            checkOutput("t2_m1_bus_read", bus_read, 1);
            tick();
            m1_read = 1'b0;
            slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
            settle();
            checkOutput("t2_m1_rvalid", m1_readdatavalid, 1);
            checkOutput("t2_m1_rdata", m1_readdata, 32'h00000003);
            checkOutput("t2_m0_quiet", m0_readdatavalid, 0);
            tick();
            slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);
        end

        // m1 write to an unmapped word times out after 16 cycles
        applyStimulus(1, 1'b0, 1'b1, 30'h000100, 32'h5A000000, 5'd1);
        settle();
        checkOutput("t3_bus_write", bus_write, 1);
        checkOutput("t3_wdata", bus_writedata, 32'h5A000000);
        checkOutput("t3_m1_wait", m1_waitrequest, 0);
        tick();
        m1_write = 1'b0;
        for (int k = 1; k < 16; k++) begin
            settle();
            checkOutput("t3_no_early_resp", {m1_writeresponsevalid, m1_readdatavalid, m0_writeresponsevalid}, 0);
            tick();
        end
        settle();
        checkOutput("t3_timeout_wrv", m1_writeresponsevalid, 1);
        checkOutput("t3_timeout_resp", m1_response, 2'b11);
        checkOutput("t3_timeout_rdv", m1_readdatavalid, 0);
        checkOutput("t3_m0_quiet", {m0_readdatavalid, m0_writeresponsevalid}, 0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
        settle();
        checkOutput("t3_back_idle", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0;
        slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
        tick();
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);

        // A real response in the timeout cycle wins over the error
        applyStimulus(0, 1'b1, 1'b0, 30'h000200, 32'h0, 5'd1);
        tick();
        m0_read = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        slaveDrive(1'b1, 1'b0, 32'hCAFE0001, 2'b00);
        settle();
        checkOutput("t3b_late_rvalid", m0_readdatavalid, 1);
        checkOutput("t3b_late_rdata", m0_readdata, 32'hCAFE0001);
        checkOutput("t3b_late_resp", m0_response, 2'b00);
        tick();
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);

        // Burst write is rejected with SLVERR and never reaches the slave
        applyStimulus(0, 1'b0, 1'b1, 30'h3e0011, 32'h12345678, 5'd4);
        settle();
        checkOutput("t4_no_bus_write", bus_write, 0);
        checkOutput("t4_m0_accept", m0_waitrequest, 0);
        tick();
        m0_write = 1'b0;
        settle();
        checkOutput("t4_wrv", m0_writeresponsevalid, 1);
        checkOutput("t4_resp", m0_response, 2'b10);
        checkOutput("t4_rdata", m0_readdata, 0);
        checkOutput("t4_no_bus_write2", bus_write, 0);
        tick();

        // Reset while m0 waits for its read data
        applyStimulus(0, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
        settle();
        checkOutput("t5_accept", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0;
        rst_n = 1'b0;
        settle();
        checkOutput("t5_no_strobe_rst", {m0_readdatavalid, m0_writeresponsevalid}, 0);
        tick();
        rst_n = 1'b1;
        slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
        settle();
        checkOutput("t5_stray_dropped", {m0_readdatavalid, m1_readdatavalid}, 0);
        checkOutput("t5_stray_rdata", m0_readdata, 0);
        tick();
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);
        applyStimulus(1, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
        settle();
        checkOutput("t5_m1_accept", m1_waitrequest, 0);
        checkOutput("t5_m1_bus_read", bus_read, 1);
        tick();
        m1_read = 1'b0;
        slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
        settle();
        checkOutput("t5_m1_rvalid", m1_readdatavalid, 1);
        checkOutput("t5_m1_resp", m1_response, 0);
        tick();
        slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);

        // Continuous contention alternates grants, starting with m0
        applyStimulus(0, 1'b1, 1'b0, 30'h3e0010, 32'h0, 5'd1);
        applyStimulus(1, 1'b0, 1'b1, 30'h3e0011, 32'h5A000000, 5'd1);
        w0 = 0;
        w1 = 0;
        for (int r = 0; r < 6; r++) begin
            settle();
            checkOutput("t6_m0_wait", m0_waitrequest, (r % 2 == 1) ? 1 : 0);
            checkOutput("t6_m1_wait", m1_waitrequest, (r % 2 == 1) ? 0 : 1);
            checkOutput("t6_bus_rw", {bus_read, bus_write}, (r % 2 == 1) ? 2'b01 : 2'b10);
            w0++;
            w1++;
            if (r % 2 == 0) begin
                checkOutput("t6_m0_wait_bound", (w0 <= 4), 1);
                w0 = 0;
            end else begin
                checkOutput("t6_m1_wait_bound", (w1 <= 4), 1);
                w1 = 0;
            end
            tick();
            if (r % 2 == 0) slaveDrive(1'b1, 1'b0, 32'h00000003, 2'b00);
            else            slaveDrive(1'b0, 1'b1, 32'h0, 2'b00);
            settle();
            checkOutput("t6_m0_rvalid", m0_readdatavalid, (r % 2 == 1) ? 0 : 1);
            checkOutput("t6_m1_wrvalid", m1_writeresponsevalid, (r % 2 == 1) ? 1 : 0);
            checkOutput("t6_busy_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
            w0++;
            w1++;
            tick();
            slaveDrive(1'b0, 1'b0, 32'h0, 2'b00);
        end
        idleAll();
        tick();

        // Slave stall holds the grant and the command
        applyStimulus(0, 1'b1, 1'b0, 30'h3e0011, 32'h0, 5'd1);
        s_waitrequest = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            checkOutput("t7_stall_m0_wait", m0_waitrequest, 1);
            checkOutput("t7_stall_bus_read", bus_read, 1);
            tick();
        end
        s_waitrequest = 1'b0;
        settle();
        checkOutput("t7_release", m0_waitrequest, 0);
        tick();
        m0_read = 1'b0;
        slaveDrive(1'b1, 1'b0, 32'h42000000, 2'b00);
        settle();
        checkOutput("t7_rdata", m0_readdata, 32'h42000000);
        tick();
        idleAll();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
